// File: rtl/i2c_slave_tx_ctrl.sv
// I2C slave-transmitter sequencer: address reception, address ACK/NACK, byte transmit and master ACK handling.
// Optional macro I2C_EMPTY_ADDR_NACK_EN: NACK a matching read address while the transmit FIFO is empty.
module i2c_slave_tx_ctrl (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       start_found,
   input  logic       stop_found,
   input  logic       scl_rise,
   input  logic       scl_fall,
   input  logic       sda_in,
   input  logic       addr_match,
   input  logic       rw_mode,
   input  logic       tx_fifo_empty,
   output logic [1:0] sda_mode,
   output logic       rx_shift_en,
   output logic       tx_load,
   output logic       tx_shift_en,
   output logic       tx_fifo_pop,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_CHK,
      ADDR_ACK,
      ADDR_NACK,
      TX_DATA,
      M_ACK,
      WAIT_STOP
   } state_t;

   localparam logic [1:0] SDA_IDLE = 2'b00;
   localparam logic [1:0] SDA_ACK  = 2'b01;
   localparam logic [1:0] SDA_NACK = 2'b10;
   localparam logic [1:0] SDA_DATA = 2'b11;

   state_t     state_q, state_d;
   logic [2:0] bitCnt_q, bitCnt_d;
   logic       addrFull_q, addrFull_d;
   logic       slotDrive_q, slotDrive_d;
   logic       mAck_q, mAck_d;
   logic [1:0] sdaMode_q, sdaMode_d;
   logic       rxShift_q, rxShift_d;
   logic       txLoad_q, txLoad_d;
   logic       txShift_q, txShift_d;
   logic       busy_q, busy_d;

   // An empty FIFO at a reload point sends a released (all-ones) byte instead of popping.
   logic [1:0] reloadMode;
   logic       reloadPop;

   assign reloadMode = tx_fifo_empty ? SDA_NACK : SDA_DATA;
   assign reloadPop  = ~tx_fifo_empty;

   always_comb begin
      state_d     = state_q;
      bitCnt_d    = bitCnt_q;
      addrFull_d  = addrFull_q;
      slotDrive_d = slotDrive_q;
      mAck_d      = mAck_q;
      sdaMode_d   = sdaMode_q;
      rxShift_d   = 1'b0;
      txLoad_d    = 1'b0;
      txShift_d   = 1'b0;

      if (stop_found) begin
         state_d     = IDLE;
         bitCnt_d    = '0;
         addrFull_d  = 1'b0;
         slotDrive_d = 1'b0;
         sdaMode_d   = SDA_IDLE;
      end else if (start_found) begin
         state_d     = ADDR;
         bitCnt_d    = '0;
         addrFull_d  = 1'b0;
         slotDrive_d = 1'b0;
         sdaMode_d   = SDA_IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               sdaMode_d = SDA_IDLE;
            end

            // The extra cycle after the 8th shift lets the external address compare settle.
            ADDR: begin
               if (addrFull_q) begin
                  addrFull_d = 1'b0;
                  state_d    = ADDR_CHK;
               end else if (scl_rise) begin
                  rxShift_d = 1'b1;
                  bitCnt_d  = bitCnt_q + 3'd1;
                  if (bitCnt_q == 3'd7) begin
                     addrFull_d = 1'b1;
                  end
               end
            end

            ADDR_CHK: begin
               slotDrive_d = 1'b0;
               if (!addr_match) begin
                  state_d   = WAIT_STOP;
                  sdaMode_d = SDA_IDLE;
               end else if (!rw_mode) begin
                  state_d = ADDR_NACK;
`ifdef I2C_EMPTY_ADDR_NACK_EN
               end else if (tx_fifo_empty) begin
                  state_d = ADDR_NACK;
`endif
               end else begin
                  state_d = ADDR_ACK;
               end
            end

            ADDR_ACK: begin
               if (scl_fall) begin
                  if (!slotDrive_q) begin
                     slotDrive_d = 1'b1;
                     sdaMode_d   = SDA_ACK;
                  end else begin
                     slotDrive_d = 1'b0;
                     bitCnt_d    = '0;
                     txLoad_d    = reloadPop;
                     sdaMode_d   = reloadMode;
                     state_d     = TX_DATA;
                  end
               end
            end

            ADDR_NACK: begin
               if (scl_fall) begin
                  if (!slotDrive_q) begin
                     slotDrive_d = 1'b1;
                     sdaMode_d   = SDA_NACK;
                  end else begin
                     slotDrive_d = 1'b0;
                     sdaMode_d   = SDA_IDLE;
                     state_d     = WAIT_STOP;
                  end
               end
            end

            TX_DATA: begin
               if (scl_fall) begin
                  if (bitCnt_q == 3'd7) begin
                     bitCnt_d  = '0;
                     sdaMode_d = SDA_IDLE;
                     mAck_d    = 1'b1;
                     state_d   = M_ACK;
                  end else begin
                     txShift_d = 1'b1;
                     bitCnt_d  = bitCnt_q + 3'd1;
                  end
               end
            end

            // A missing rise before the fall leaves the sample at NACK.
            M_ACK: begin
               if (scl_fall) begin
                  if (!mAck_q) begin
                     bitCnt_d  = '0;
                     txLoad_d  = reloadPop;
                     sdaMode_d = reloadMode;
                     state_d   = TX_DATA;
                  end else begin
                     sdaMode_d = SDA_IDLE;
                     state_d   = WAIT_STOP;
                  end
               end else if (scl_rise) begin
                  mAck_d = sda_in;
               end
            end

            WAIT_STOP: begin
               sdaMode_d = SDA_IDLE;
            end

            default: begin
               state_d   = IDLE;
               sdaMode_d = SDA_IDLE;
            end
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         bitCnt_q    <= '0;
         addrFull_q  <= 1'b0;
         slotDrive_q <= 1'b0;
         mAck_q      <= 1'b1;
         sdaMode_q   <= SDA_IDLE;
         rxShift_q   <= 1'b0;
         txLoad_q    <= 1'b0;
         txShift_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bitCnt_q    <= bitCnt_d;
         addrFull_q  <= addrFull_d;
         slotDrive_q <= slotDrive_d;
         mAck_q      <= mAck_d;
         sdaMode_q   <= sdaMode_d;
         rxShift_q   <= rxShift_d;
         txLoad_q    <= txLoad_d;
         txShift_q   <= txShift_d;
         busy_q      <= busy_d;
      end
   end

   assign sda_mode    = sdaMode_q;
   assign rx_shift_en = rxShift_q;
   assign tx_load     = txLoad_q;
   assign tx_fifo_pop = txLoad_q;
   assign tx_shift_en = txShift_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_i2c_slave_tx_ctrl.sv
// Scoreboard bench for i2c_slave_tx_ctrl: protocol-level model predicts output events, a monitor compares them.
// Honours I2C_EMPTY_ADDR_NACK_EN the same way as the design build.
module tb_i2c_slave_tx_ctrl;

   localparam logic [6:0] OWN = 7'h51;
`ifdef I2C_EMPTY_ADDR_NACK_EN
   localparam bit NACK_EMPTY = 1'b1;
`else
   localparam bit NACK_EMPTY = 1'b0;
`endif
   localparam logic [3:0] P_RX    = 4'b1000;
   localparam logic [3:0] P_LOAD  = 4'b0101;
   localparam logic [3:0] P_SHIFT = 4'b0010;
   localparam int O_NONE = 0;
   localparam int O_ACK  = 1;
   localparam int O_NACK = 2;

   logic       clk = 1'b0;
   logic       n_rst, start_found, stop_found, scl_rise, scl_fall, sda_in;
   logic       addr_match, rw_mode, tx_fifo_empty;
   logic [1:0] sda_mode;
   logic       rx_shift_en, tx_load, tx_shift_en, tx_fifo_pop, busy;

   typedef struct {
      string name;
      int    got;
      int    exp;
   } req_t;

   int   expQ[$];
   req_t reqQ[$];
   int   checkCnt = 0;
   int   passCnt = 0;
   bit   monOn = 1'b0;

   logic [7:0] envFifo[$];
   logic [7:0] modelFifo[$];
   logic [7:0] txSr = 8'h00;
   logic [7:0] addrSr = 8'h00;
   logic [7:0] curExpByte = 8'h00;
   logic [7:0] dummy;
   bit         pendRx = 1'b0;
   logic [1:0] mSda = 2'b00;
   logic       mBusy = 1'b0;
   int         popCnt = 0;
   int         loadCnt = 0;
   int         shiftCnt = 0;

   i2c_slave_tx_ctrl dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .start_found  (start_found),
      .stop_found   (stop_found),
      .scl_rise     (scl_rise),
      .scl_fall     (scl_fall),
      .sda_in       (sda_in),
      .addr_match   (addr_match),
      .rw_mode      (rw_mode),
      .tx_fifo_empty(tx_fifo_empty),
      .sda_mode     (sda_mode),
      .rx_shift_en  (rx_shift_en),
      .tx_load      (tx_load),
      .tx_shift_en  (tx_shift_en),
      .tx_fifo_pop  (tx_fifo_pop),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Monitor: turns output activity into event tokens and compares them with the predicted queue.
   task automatic compare(string name, int got, int exp);
      checkCnt++;
      if (got == exp) passCnt++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
   endtask

   task automatic score(int tok);
      int e;
      if (expQ.size() > 0) e = expQ.pop_front();
      else e = -1;
      compare("sb_token", tok, e);
   endtask

   logic [1:0] prevSda;
   logic       prevBusy;
   always @(negedge clk) begin : monitor
      logic [3:0] pulses;
      req_t r;
      if (!monOn) begin
         prevSda  = sda_mode;
         prevBusy = busy;
      end else begin
         pulses = {rx_shift_en, tx_load, tx_shift_en, tx_fifo_pop};
         if (pulses != 4'b0000) score({26'd0, 2'd1, pulses});
         if (sda_mode != prevSda) score({26'd0, 2'd2, 2'b00, sda_mode});
         if (busy != prevBusy) score({26'd0, 2'd3, 3'b000, busy});
         prevSda  = sda_mode;
         prevBusy = busy;
      end
      while (reqQ.size() > 0) begin
         r = reqQ.pop_front();
         compare(r.name, r.got, r.exp);
      end
   end

   // Expectation helpers: tokens are pushed only when the predicted output actually changes.
   task automatic expPulse(logic [3:0] p);
      expQ.push_back({26'd0, 2'd1, p});
   endtask

   task automatic expSda(logic [1:0] m);
      if (m != mSda) expQ.push_back({26'd0, 2'd2, 2'b00, m});
      mSda = m;
   endtask

   task automatic expBusy(logic b);
      if (b != mBusy) expQ.push_back({26'd0, 2'd3, 3'b000, b});
      mBusy = b;
   endtask

   task automatic reqCheck(string name, int got, int exp);
      reqQ.push_back('{name, got, exp});
   endtask

   // Environment: external address register, transmit FIFO and shift register around the DUT.
   task automatic tick();
      @(posedge clk);
      #1;
      if (pendRx) begin
         addrSr     = {addrSr[6:0], sda_in};
         addr_match = (addrSr[7:1] == OWN);
         rw_mode    = addrSr[0];
         pendRx     = 1'b0;
      end
      if (rx_shift_en) pendRx = 1'b1;
      if (tx_load) begin
         loadCnt++;
         txSr = (envFifo.size() > 0) ? envFifo[0] : 8'hEE;
      end else if (tx_shift_en) begin
         shiftCnt++;
         txSr = {txSr[6:0], 1'b0};
      end
      if (tx_fifo_pop) begin
         popCnt++;
         if (envFifo.size() > 0) dummy = envFifo.pop_front();
      end
      tx_fifo_empty = (envFifo.size() == 0);
   endtask

   task automatic idle(int n);
      repeat (n) tick();
   endtask

   task automatic fillFifo(logic [7:0] b);
      envFifo.push_back(b);
      modelFifo.push_back(b);
      tx_fifo_empty = 1'b0;
   endtask

   task automatic flushFifo();
      envFifo.delete();
      modelFifo.delete();
      tx_fifo_empty = 1'b1;
   endtask

   function automatic logic slaveLevel();
      case (sda_mode)
         2'b01:   return 1'b0;
         2'b11:   return txSr[7];
         default: return 1'b1;
      endcase
   endfunction

   task automatic sclBit(logic v, output logic lvl);
      sda_in = v;
      idle(2);
      lvl = slaveLevel();
      scl_rise = 1'b1;
      tick();
      scl_rise = 1'b0;
      idle(3);
      scl_fall = 1'b1;
      tick();
      scl_fall = 1'b0;
      idle(2);
   endtask

   task automatic doStart();
      expSda(2'b00);
      expBusy(1'b1);
      start_found = 1'b1;
      tick();
      start_found = 1'b0;
      idle(2);
   endtask

   task automatic doStop();
      expSda(2'b00);
      expBusy(1'b0);
      stop_found = 1'b1;
      tick();
      stop_found = 1'b0;
      idle(2);
   endtask

   // Reference model of one protocol step each: what the slave should do on the bus.
   task automatic reload();
      if (modelFifo.size() > 0) begin
         expPulse(P_LOAD);
         expSda(2'b11);
         curExpByte = modelFifo.pop_front();
      end else begin
         expSda(2'b10);
         curExpByte = 8'hFF;
      end
   endtask

   task automatic addrByte(logic [7:0] a, output int oc);
      logic lvl;
      if (a[7:1] != OWN) oc = O_NONE;
      else if (!a[0]) oc = O_NACK;
      else if (NACK_EMPTY && modelFifo.size() == 0) oc = O_NACK;
      else oc = O_ACK;
      for (int i = 7; i >= 0; i--) begin
         expPulse(P_RX);
         if (i == 0 && oc == O_ACK) expSda(2'b01);
         if (i == 0 && oc == O_NACK) expSda(2'b10);
         sclBit(a[i], lvl);
      end
   endtask

   task automatic ackSlot(int oc);
      logic lvl;
      if (oc == O_ACK) reload();
      else if (oc == O_NACK) expSda(2'b00);
      sclBit(1'b1, lvl);
      if (oc != O_NONE) reqCheck("ack_slot_level", int'(lvl), (oc == O_ACK) ? 0 : 1);
   endtask

   task automatic dataByte(int nBits);
      logic lvl;
      logic [7:0] got;
      got = 8'h00;
      for (int i = 0; i < nBits; i++) begin
         if (i < 7) expPulse(P_SHIFT);
         else expSda(2'b00);
         sclBit(1'b1, lvl);
         got = {got[6:0], lvl};
      end
      if (nBits == 8) reqCheck("rd_byte", int'(got), int'(curExpByte));
   endtask

   task automatic mAckSlot(logic nack);
      logic lvl;
      if (!nack) reload();
      sclBit(nack, lvl);
   endtask

   task automatic readTxn(logic [7:0] a, int nBytes);
      int oc;
      logic lvl;
      doStart();
      addrByte(a, oc);
      ackSlot(oc);
      if (oc == O_ACK) begin
         for (int b = 0; b < nBytes; b++) begin
            dataByte(8);
            mAckSlot(b == nBytes - 1);
         end
      end
      sclBit(1'b1, lvl);
      sclBit(1'b0, lvl);
      idle(4);
      reqCheck("sb_drain", expQ.size(), 0);
      reqCheck("busy_before_stop", int'(busy), 1);
   endtask

   task automatic applyStimulus();
      int oc;
      int p0, l0, s0;
      logic lvl;
      logic [7:0] a;

      // Reset with competing bus events must still land in idle.
      n_rst = 1'b0;
      start_found = 1'b1;
      scl_rise = 1'b1;
      scl_fall = 1'b1;
      tick();
      start_found = 1'b0;
      scl_rise = 1'b0;
      scl_fall = 1'b0;
      reqCheck("rst_sda", int'(sda_mode), 0);
      reqCheck("rst_busy", int'(busy), 0);
      reqCheck("rst_pulses", int'({rx_shift_en, tx_load, tx_shift_en, tx_fifo_pop}), 0);
      idle(2);
      n_rst = 1'b1;
      idle(2);
      monOn = 1'b1;
      idle(1);

      $display("[TB] single-byte read of 0xA5");
      fillFifo(8'hA5);
      l0 = loadCnt;
      s0 = shiftCnt;
      readTxn({OWN, 1'b1}, 1);
      reqCheck("one_byte_loads", loadCnt - l0, 1);
      reqCheck("one_byte_shifts", shiftCnt - s0, 7);
      doStop();

      $display("[TB] two-byte read, ACK then NACK");
      flushFifo();
      fillFifo(8'h12);
      fillFifo(8'h34);
      p0 = popCnt;
      readTxn({OWN, 1'b1}, 2);
      reqCheck("two_byte_pops", popCnt - p0, 2);
      doStop();
      reqCheck("idle_after_stop", int'(busy), 0);

      $display("[TB] matching write address");
      fillFifo(8'h77);
      l0 = loadCnt;
      readTxn({OWN, 1'b0}, 1);
      reqCheck("write_no_load", loadCnt - l0, 0);
      doStop();

      $display("[TB] read with empty FIFO");
      flushFifo();
      p0 = popCnt;
      readTxn({OWN, 1'b1}, 1);
      reqCheck("empty_no_pop", popCnt - p0, 0);
      doStop();

      $display("[TB] repeated START after four data bits");
      fillFifo(8'hC3);
      fillFifo(8'h5A);
      doStart();
      addrByte({OWN, 1'b1}, oc);
      ackSlot(oc);
      dataByte(4);
      doStart();
      s0 = shiftCnt;
      addrByte({OWN, 1'b1}, oc);
      reqCheck("rstart_no_shift", shiftCnt - s0, 0);
      ackSlot(oc);
      dataByte(8);
      mAckSlot(1'b1);
      idle(4);
      reqCheck("sb_drain", expQ.size(), 0);
      doStop();

      $display("[TB] reset in the middle of a data byte");
      flushFifo();
      fillFifo(8'h96);
      doStart();
      addrByte({OWN, 1'b1}, oc);
      ackSlot(oc);
      dataByte(3);
      sda_in = 1'b1;
      idle(2);
      scl_rise = 1'b1;
      tick();
      scl_rise = 1'b0;
      idle(2);
      expSda(2'b00);
      expBusy(1'b0);
      n_rst = 1'b0;
      tick();
      n_rst = 1'b1;
      reqCheck("rst_tx_sda", int'(sda_mode), 0);
      reqCheck("rst_tx_busy", int'(busy), 0);
      idle(3);

      $display("[TB] STOP coinciding with SCL fall");
      fillFifo(8'h3C);
      doStart();
      addrByte({OWN, 1'b1}, oc);
      ackSlot(oc);
      dataByte(2);
      sda_in = 1'b1;
      idle(2);
      scl_rise = 1'b1;
      tick();
      scl_rise = 1'b0;
      idle(2);
      expSda(2'b00);
      expBusy(1'b0);
      s0 = shiftCnt;
      stop_found = 1'b1;
      scl_fall = 1'b1;
      tick();
      stop_found = 1'b0;
      scl_fall = 1'b0;
      idle(3);
      reqCheck("stopfall_no_shift", shiftCnt - s0, 0);
      reqCheck("stopfall_busy", int'(busy), 0);

      $display("[TB] randomized transactions");
      flushFifo();
      for (int t = 0; t < 14; t++) begin
         for (int k = $urandom_range(0, 3); k > 0; k--) fillFifo(8'($urandom));
         case ($urandom_range(0, 5))
            0: begin
               a[7:1] = 7'($urandom_range(0, 127));
               if (a[7:1] == OWN) a[7:1] = OWN ^ 7'h01;
               a[0] = 1'($urandom);
            end
            1: a = {OWN, 1'b0};
            default: a = {OWN, 1'b1};
         endcase
         readTxn(a, $urandom_range(1, 3));
         doStop();
      end
      sclBit(1'b1, lvl);
   endtask

   task automatic checkOutput();
      idle(4);
      reqCheck("sb_final_drain", expQ.size(), 0);
      reqCheck("final_busy", int'(busy), 0);
      idle(3);
   endtask

   initial begin
      n_rst = 1'b0;
      start_found = 1'b0;
      stop_found = 1'b0;
      scl_rise = 1'b0;
      scl_fall = 1'b0;
      sda_in = 1'b1;
      addr_match = 1'b0;
      rw_mode = 1'b0;
      tx_fifo_empty = 1'b1;
      applyStimulus();
      checkOutput();
      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
